// File: rtl/sm_reg_uart_dump_pkg.sv
// Shared types, ASCII constants and nibble-to-hex helper for the register UART dump.
// SM_REG_DUMP_ADDR_PREFIX_EN adds a "AA: " address prefix to every dumped line.
package sm_reg_uart_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETADDR,
    S_LATCH,
    S_SEND,
    S_NEXT
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_COLON      = 8'h3A;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_ZERO       = 8'h30;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
  localparam int unsigned PREFIX_LEN = 4;
`else
  localparam int unsigned PREFIX_LEN = 0;
`endif
  localparam int unsigned LINE_LEN = PREFIX_LEN + 10;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_ZERO + {4'h0, n}) : (ASCII_A_MINUS_10 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sm_reg_uart_dump_tx.sv
// UART 8N1 byte serializer with valid/ready handshake; ready rises in the last
// stop-bit cycle so a waiting byte starts with no idle gap.
module sm_uart_tx_byte
  import sm_reg_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] PRE_LAST = 16'(CLKS_PER_BIT - 2);

  tx_state_t   state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end = (clk_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (valid) begin
            shreg   <= data;
            tx      <= 1'b0;
            ready   <= 1'b0;
            clk_cnt <= '0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= TX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          // Last stop cycle doubles as idle: a pending byte is taken directly.
          if (bit_end) begin
            clk_cnt <= '0;
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              ready <= 1'b0;
              state <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
            if (clk_cnt == PRE_LAST) ready <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sm_reg_uart_dump.sv
// Sweeps the core debug register port and prints each register as hex text over UART.
// SM_REG_DUMP_ADDR_PREFIX_EN prefixes each line with the two-digit address and ": ".
module sm_reg_uart_dump
  import sm_reg_uart_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        uartTx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
  localparam logic [3:0] LAST_CHAR = 4'(LINE_LEN - 1);

  dump_state_t state;
  logic [4:0]  cur;
  logic [31:0] hold;
  logic [3:0]  char_idx;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic [3:0]  digit;
  logic [3:0]  nib;

  always_comb begin
    tx_byte = ASCII_LF;
    digit   = char_idx - 4'(PREFIX_LEN);
    nib     = 4'(hold >> (5'd28 - {digit[2:0], 2'b00}));
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
    if (char_idx == 4'd0)      tx_byte = nibble_to_ascii({3'b000, regAddr[4]});
    else if (char_idx == 4'd1) tx_byte = nibble_to_ascii(regAddr[3:0]);
    else if (char_idx == 4'd2) tx_byte = ASCII_COLON;
    else if (char_idx == 4'd3) tx_byte = ASCII_SPACE;
    else
`endif
    if (digit < 4'd8)       tx_byte = nibble_to_ascii(nib);
    else if (digit == 4'd8) tx_byte = ASCII_CR;
    else                    tx_byte = ASCII_LF;
  end

  // Next register is fetched while the LF frame is still on the wire, so lines run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      hold     <= '0;
      char_idx <= '0;
      tx_valid <= 1'b0;
      regAddr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cur   <= '0;
            state <= S_SETADDR;
          end
        end
        S_SETADDR: begin
          regAddr <= cur;
          state   <= S_LATCH;
        end
        S_LATCH: begin
          hold     <= regData;
          char_idx <= '0;
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            if (char_idx == LAST_CHAR) begin
              tx_valid <= 1'b0;
              state    <= S_NEXT;
            end else begin
              char_idx <= char_idx + 4'd1;
            end
          end
        end
        S_NEXT: begin
          if (cur == LAST_REG) begin
            if (tx_ready) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              regAddr <= '0;
              state   <= S_IDLE;
            end
          end else begin
            cur   <= cur + 5'd1;
            state <= S_SETADDR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sm_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_byte),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (uartTx)
  );

endmodule

// File: tb/tb_sm_reg_uart_dump.sv
// Scoreboard bench for sm_reg_uart_dump: expected bytes are queued at each start,
// a UART receiver pops and compares. Honours SM_REG_DUMP_ADDR_PREFIX_EN.
module tb_sm_reg_uart_dump;

  localparam int unsigned CPB = 4;
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
  localparam int DONE_CYC = 17923;
  localparam logic [7:0] FIRST_BYTE = 8'h30;
`else
  localparam int DONE_CYC = 12803;
  localparam logic [7:0] FIRST_BYTE = 8'h31;
`endif
  localparam logic [7:0] LIT [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};

  typedef struct {
    logic [7:0] b;
    bit         chk;
    logic [4:0] a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        uart_tx;
  logic        busy;
  logic        done;

  bit   mode;
  bit   mon_en;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb reg_data = mode ? ({27'b0, reg_addr} * 32'h01010101) : 32'h1234ABCD;

  sm_reg_uart_dump #(
    .CLKS_PER_BIT(CPB),
    .NUM_REGS    (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .regAddr (reg_addr),
    .regData (reg_data),
    .uartTx  (uart_tx),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int unsigned n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  function automatic void push_byte(input logic [7:0] b, input bit chk, input logic [4:0] a);
    exp_t e;
    e.b = b; e.chk = chk; e.a = a;
    sb.push_back(e);
  endfunction

  function automatic void push_dump(input bit pattern);
    logic [31:0] d;
    for (int r = 0; r < 32; r++) begin
      logic [4:0] a;
      a = 5'(r);
      d = {a[3:0], 4'h0, a[3:0], 4'h0, a[3:0], 4'h0, a[3:0], 4'h0} >> 4;
      d = d | ({27'b0, a} << 24) | ({27'b0, a} << 16) | ({27'b0, a} << 8) | {27'b0, a};
`ifdef SM_REG_DUMP_ADDR_PREFIX_EN
      push_byte(hexc(r / 16), 1'b1, a);
      push_byte(hexc(r % 16), 1'b1, a);
      push_byte(8'h3A, 1'b1, a);
      push_byte(8'h20, 1'b1, a);
`endif
      for (int k = 0; k < 8; k++) begin
        if (pattern) push_byte(hexc(int'((d >> (28 - 4 * k)) & 32'hF)), 1'b1, a);
        else         push_byte(LIT[k], 1'b1, a);
      end
      push_byte(8'h0D, 1'b1, a);
      push_byte(8'h0A, 1'b0, a);
    end
  endfunction

  // UART receiver: samples bit centres on negedges, compares against the queue head.
  int         rx_cnt;
  bit         rx_busy;
  logic [7:0] rx_byte;
  logic       rx_start;
  always @(negedge clk) begin
    if (!mon_en) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (uart_tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2) rx_start = uart_tx;
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
        rx_byte[(rx_cnt - 6) / 4] = uart_tx;
      if (rx_cnt == 38) begin
        rx_busy = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_byte", {55'b0, rx_start, rx_byte}, 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("uart_frame", {54'b0, rx_start, rx_byte, uart_tx}, {54'b0, 1'b0, e.b, 1'b1});
          if (e.chk) check("reg_addr_in_line", {59'b0, reg_addr}, {59'b0, e.a});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [63:0] cap;
    logic [63:0] exp_cap;
    int          lat;
    bit          ok;
    bit          seen_low;

    rst = 1'b1; start = 1'b0; mode = 1'b0; mon_en = 1'b0;
    tick; tick;
    start = 1'b1; tick; start = 1'b0; tick;
    check("reset_uartTx", {63'b0, uart_tx}, 64'd1);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_regAddr", {59'b0, reg_addr}, 64'd0);
    rst = 1'b0;
    tick; tick; tick;
    check("start_in_reset_ignored", {62'b0, busy, uart_tx}, 64'd1);

    // Dump 1: constant data, check first-frame waveform and completion time.
    mon_en = 1'b1;
    push_dump(1'b0);
    start = 1'b1; tick; start_cyc = cyc; start = 1'b0;
    cap = '0;
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      cap[j] = uart_tx;
      if (j == 0) check("busy_after_start", {63'b0, busy}, 64'd1);
    end
    exp_cap = '0;
    for (int j = 0; j <= 42; j++) begin
      if (j < 3 || j >= 39)  exp_cap[j] = 1'b1;
      else if (j < 7)        exp_cap[j] = 1'b0;
      else                   exp_cap[j] = FIRST_BYTE[(j - 7) / 4];
    end
    check("first_frame_wave", cap, exp_cap);
    wait_done(25000, lat, ok);
    check("dump1_done_seen", {63'b0, ok}, 64'd1);
    check("dump1_done_latency", 64'(lat), 64'(DONE_CYC));
    check("dump1_end_busy_addr", {58'b0, busy, reg_addr}, 64'd0);
    @(negedge clk);
    check("dump1_done_one_cycle", {63'b0, done}, 64'd0);

    // Dump 2: address pattern; mid-dump start pulse, then start held across done.
    @(posedge clk); #1;
    mode = 1'b1;
    push_dump(1'b1);
    start = 1'b1; tick; start_cyc = cyc; start = 1'b0;
    repeat (1000) tick;
    start = 1'b1; tick; start = 1'b0;
    repeat (11500) tick;
    start = 1'b1;
    wait_done(25000, lat, ok);
    check("dump2_done_seen", {63'b0, ok}, 64'd1);
    check("dump2_done_latency", 64'(lat), 64'(DONE_CYC));
    check("dump2_end_addr", {59'b0, reg_addr}, 64'd0);
    push_dump(1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("held_start_restarts", {63'b0, busy}, 64'd1);

    // Dump 3: reset in the middle of a frame.
    repeat (300) tick;
    seen_low = 1'b0;
    for (int i = 0; i < 100 && !seen_low; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) seen_low = 1'b1;
    end
    check("tx_low_before_abort", {63'b0, seen_low}, 64'd1);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_uartTx_immediate", {63'b0, uart_tx}, 64'd1);
    check("abort_busy_done_addr", {57'b0, busy, done, reg_addr}, 64'd0);
    tick; tick;
    sb.delete();
    rst = 1'b0;
    tick; tick;
    check("after_abort_idle", {62'b0, busy, uart_tx}, 64'd1);

    // Dump 4: fresh dump must start again at register 0.
    mon_en = 1'b1;
    push_dump(1'b1);
    start = 1'b1; tick; start_cyc = cyc; start = 1'b0;
    wait_done(25000, lat, ok);
    check("dump4_done_seen", {63'b0, ok}, 64'd1);
    check("dump4_done_latency", 64'(lat), 64'(DONE_CYC));
    check("dump4_end_busy_addr", {58'b0, busy, reg_addr}, 64'd0);
    repeat (5) tick;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
